// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings, ALU operations and pipeline bundles
// shared by the riscv_cpu five-stage core and its ALU.
package riscv_pkg;

    localparam logic [31:0] NOP_ENC = 32'h00000013;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    function automatic if_id_t if_id_nop();
        if_id_t r;
        r = '0;
        r.instr = NOP_ENC;
        return r;
    endfunction

    function automatic id_ex_t id_ex_nop();
        id_ex_t r;
        r = '0;
        r.instr = NOP_ENC;
        return r;
    endfunction

    function automatic ex_mem_t ex_mem_nop();
        ex_mem_t r;
        r = '0;
        r.instr = NOP_ENC;
        return r;
    endfunction

    function automatic mem_wb_t mem_wb_nop();
        mem_wb_t r;
        r = '0;
        r.instr = NOP_ENC;
        return r;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational integer ALU for the EX stage.
// zero doubles as the BEQ equality flag when op is SUB.
module riscv_alu
    import riscv_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    // select the operation; SLT compares as signed
    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/riscv_cpu.sv
// riscv_cpu: five-stage in-order RV32I-subset core with
// forwarding, load-use stall and flush-on-taken-branch.
module riscv_cpu
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input logic clock,
    input logic reset
);

    localparam logic [31:0] NOP = NOP_ENC;
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] IMemory [0:IMEM_WORDS-1];
    logic [31:0] DMemory [0:DMEM_WORDS-1];
    logic [31:0] Regs    [0:31];

    logic [31:0] pc;
    if_id_t      ifid;
    id_ex_t      idex;
    ex_mem_t     exmem;
    mem_wb_t     memwb;

    // ---------------- IF ----------------
    if_id_t ifid_next;
    assign ifid_next.pc    = pc;
    assign ifid_next.instr = IMemory[pc[IAW+1:2]];

    // ---------------- ID ----------------
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    assign opc    = ifid.instr[6:0];
    assign id_rd  = ifid.instr[11:7];
    assign f3     = ifid.instr[14:12];
    assign id_rs1 = ifid.instr[19:15];
    assign id_rs2 = ifid.instr[24:20];
    assign f7     = ifid.instr[31:25];

    assign imm_i = {{20{ifid.instr[31]}}, ifid.instr[31:20]};
    assign imm_s = {{20{ifid.instr[31]}}, ifid.instr[31:25],
                    ifid.instr[11:7]};
    assign imm_b = {{19{ifid.instr[31]}}, ifid.instr[31],
                    ifid.instr[7], ifid.instr[30:25],
                    ifid.instr[11:8], 1'b0};

    alu_op_t r_op;
    logic    r_ok;

    // map funct7/funct3 of an R-type to an ALU op
    always_comb begin
        r_ok = 1'b1;
        r_op = ALU_ADD;
        unique case ({f7, f3})
            {F7_BASE, F3_ADD}: r_op = ALU_ADD;
            {F7_SUB,  F3_ADD}: r_op = ALU_SUB;
            {F7_BASE, F3_AND}: r_op = ALU_AND;
            {F7_BASE, F3_OR}:  r_op = ALU_OR;
            {F7_BASE, F3_SLT}: r_op = ALU_SLT;
            default:           r_ok = 1'b0;
        endcase
    end

    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;

    assign is_r    = (opc == OP_R) && r_ok;
    assign is_addi = (opc == OP_IMM) && (f3 == F3_ADD);
    assign is_lw   = (opc == OP_LOAD) && (f3 == F3_W);
    assign is_sw   = (opc == OP_STORE) && (f3 == F3_W);
    assign is_beq  = (opc == OP_BR) && (f3 == F3_BEQ);

    // register read with same-cycle WB write returned to ID
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        wb_hit1;
    logic        wb_hit2;

    assign wb_hit1 = memwb.reg_write && (memwb.rd == id_rs1);
    assign wb_hit2 = memwb.reg_write && (memwb.rd == id_rs2);
    assign rs1_val = (id_rs1 == 5'd0) ? '0 :
                     wb_hit1 ? memwb.wb_data : Regs[id_rs1];
    assign rs2_val = (id_rs2 == 5'd0) ? '0 :
                     wb_hit2 ? memwb.wb_data : Regs[id_rs2];

    id_ex_t idex_next;

    // decode; unsupported encodings keep all controls cleared
    always_comb begin
        idex_next         = id_ex_nop();
        idex_next.pc      = ifid.pc;
        idex_next.instr   = ifid.instr;
        idex_next.rs1     = id_rs1;
        idex_next.rs2     = id_rs2;
        idex_next.rd      = id_rd;
        idex_next.rs1_val = rs1_val;
        idex_next.rs2_val = rs2_val;
        unique case (1'b1)
            is_r: begin
                idex_next.alu_op    = r_op;
                idex_next.reg_write = 1'b1;
            end
            is_addi: begin
                idex_next.imm       = imm_i;
                idex_next.alu_src   = 1'b1;
                idex_next.reg_write = 1'b1;
            end
            is_lw: begin
                idex_next.imm       = imm_i;
                idex_next.alu_src   = 1'b1;
                idex_next.reg_write = 1'b1;
                idex_next.mem_read  = 1'b1;
            end
            is_sw: begin
                idex_next.imm       = imm_s;
                idex_next.alu_src   = 1'b1;
                idex_next.mem_write = 1'b1;
            end
            is_beq: begin
                idex_next.imm    = imm_b;
                idex_next.alu_op = ALU_SUB;
                idex_next.branch = 1'b1;
            end
            default: ;
        endcase
    end

    logic load_use;
    assign load_use = idex.mem_read && (idex.rd != 5'd0) &&
                      ((idex.rd == id_rs1) || (idex.rd == id_rs2));

    // ---------------- EX ----------------
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    // operand forwarding, EX/MEM ahead of MEM/WB
    always_comb begin
        fwd_a = idex.rs1_val;
        fwd_b = idex.rs2_val;
        if (exmem.reg_write && exmem.rd != 5'd0 &&
            exmem.rd == idex.rs1)
            fwd_a = exmem.alu_res;
        else if (memwb.reg_write && memwb.rd != 5'd0 &&
                 memwb.rd == idex.rs1)
            fwd_a = memwb.wb_data;
        if (exmem.reg_write && exmem.rd != 5'd0 &&
            exmem.rd == idex.rs2)
            fwd_b = exmem.alu_res;
        else if (memwb.reg_write && memwb.rd != 5'd0 &&
                 memwb.rd == idex.rs2)
            fwd_b = memwb.wb_data;
    end

    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        taken;
    logic [31:0] target;

    assign alu_b = idex.alu_src ? idex.imm : fwd_b;

    riscv_alu u_alu (
        .op     (idex.alu_op),
        .a      (fwd_a),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign taken  = idex.branch && alu_zero;
    assign target = idex.pc + idex.imm;

    ex_mem_t exmem_next;
    assign exmem_next.instr      = idex.instr;
    assign exmem_next.alu_res    = alu_res;
    assign exmem_next.store_data = fwd_b;
    assign exmem_next.rd         = idex.rd;
    assign exmem_next.reg_write  = idex.reg_write;
    assign exmem_next.mem_read   = idex.mem_read;
    assign exmem_next.mem_write  = idex.mem_write;

    // ---------------- MEM ----------------
    logic [DAW-1:0] dmem_idx;
    logic [31:0]    mem_rdata;
    mem_wb_t        memwb_next;

    assign dmem_idx  = exmem.alu_res[DAW+1:2];
    assign mem_rdata = DMemory[dmem_idx];

    assign memwb_next.instr     = exmem.instr;
    assign memwb_next.wb_data   = exmem.mem_read ? mem_rdata
                                                 : exmem.alu_res;
    assign memwb_next.rd        = exmem.rd;
    assign memwb_next.reg_write = exmem.reg_write;

    // PC and pipeline registers; a taken branch outranks a stall
    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= '0;
            ifid  <= if_id_nop();
            idex  <= id_ex_nop();
            exmem <= ex_mem_nop();
            memwb <= mem_wb_nop();
        end else begin
            exmem <= exmem_next;
            memwb <= memwb_next;
            if (taken) begin
                pc   <= target;
                ifid <= if_id_nop();
                idex <= id_ex_nop();
            end else if (load_use) begin
                idex <= id_ex_nop();
            end else begin
                pc   <= pc + 32'd4;
                ifid <= ifid_next;
                idex <= idex_next;
            end
        end
    end

    // WB register write; x0 stays zero, reset squashes the write
    always_ff @(posedge clock) begin
        if (!reset && memwb.reg_write && memwb.rd != 5'd0)
            Regs[memwb.rd] <= memwb.wb_data;
    end

    // store at the end of MEM; reset squashes the write
    always_ff @(posedge clock) begin
        if (!reset && exmem.mem_write)
            DMemory[dmem_idx] <= exmem.store_data;
    end

endmodule

// File: tb/tb_riscv_cpu.sv
// tb_riscv_cpu: directed programs for riscv_cpu with results
// read back from the register file and data memory.
module tb_riscv_cpu;

    localparam logic [31:0] NOPW = 32'h00000013;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;

    riscv_cpu #(
        .IMEM_WORDS (1024),
        .DMEM_WORDS (1024)
    ) dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] i_r(input logic [6:0] f7,
        input logic [2:0] f3, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_add(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2);
        return i_r(7'h00, 3'b000, rd, rs1, rs2);
    endfunction

    function automatic logic [31:0] i_sub(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2);
        return i_r(7'h20, 3'b000, rd, rs1, rs2);
    endfunction

    function automatic logic [31:0] i_addi(input logic [4:0] rd,
        input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd,
        input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] i_st(input logic [2:0] f3,
        input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] i_beq(input logic [4:0] rs1,
        input logic [4:0] rs2, input int imm);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11],
                7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) dut.IMemory[i] = NOPW;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        dut.IMemory[a] = w;
    endtask

    task automatic start();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    logic [31:0] beq_w;

    initial begin
        // ---- forwarding and ALU ops ----
        reset = 1'b1;
        clear_imem();
        put(0, i_addi(1, 0, 0));
        put(1, i_addi(4, 0, 0));
        put(2, i_addi(7, 0, 0));
        put(6, i_addi(1, 0, 10));
        put(7, i_add(4, 1, 0));
        put(8, i_addi(7, 0, 3));
        put(10, i_add(8, 7, 7));
        put(11, i_sub(9, 8, 4));
        put(12, i_r(7'h00, 3'b010, 10, 9, 8));
        put(13, i_r(7'h00, 3'b110, 11, 9, 1));
        put(14, i_r(7'h00, 3'b111, 12, 9, 1));
        put(15, i_addi(13, 0, 1));
        put(16, i_addi(13, 0, 2));
        put(17, i_add(14, 13, 0));
        start();
        chk("rst_pc", dut.pc, 32'd0);
        chk("rst_ifid", dut.ifid.instr, NOPW);
        chk("rst_idex", dut.idex.instr, NOPW);
        chk("rst_exmem", dut.exmem.instr, NOPW);
        chk("rst_memwb", dut.memwb.instr, NOPW);
        chk("rst_idex_we", {31'b0, dut.idex.reg_write}, 32'd0);
        tick(25);
        chk("fwd_x1", dut.Regs[1], 32'd10);
        chk("fwd_x4", dut.Regs[4], 32'd10);
        chk("memwb_x8", dut.Regs[8], 32'd6);
        chk("sub_x9", dut.Regs[9], 32'hFFFF_FFFC);
        chk("slt_x10", dut.Regs[10], 32'd1);
        chk("or_x11", dut.Regs[11], 32'hFFFF_FFFE);
        chk("and_x12", dut.Regs[12], 32'd8);
        chk("prio_x13", dut.Regs[13], 32'd2);
        chk("prio_x14", dut.Regs[14], 32'd2);

        // ---- load-use stall ----
        reset = 1'b1;
        clear_imem();
        dut.DMemory[0] = 32'd5;
        put(0, i_lw(2, 0, 0));
        put(1, i_add(5, 2, 2));
        start();
        tick(1);
        chk("lu_pc_e1", dut.pc, 32'd4);
        tick(1);
        chk("lu_pc_e2", dut.pc, 32'd8);
        tick(1);
        chk("lu_pc_hold", dut.pc, 32'd8);
        tick(1);
        chk("lu_pc_e4", dut.pc, 32'd12);
        tick(6);
        chk("lu_x2", dut.Regs[2], 32'd5);
        chk("lu_x5", dut.Regs[5], 32'd10);

        // ---- branch flush and not-taken ----
        reset = 1'b1;
        clear_imem();
        put(0, i_addi(3, 0, 0));
        put(1, i_addi(4, 0, 0));
        put(2, i_addi(1, 0, 1));
        put(3, i_beq(1, 1, 12));
        put(4, i_addi(3, 0, 7));
        put(5, i_addi(3, 0, 9));
        put(6, i_addi(4, 0, 10));
        put(7, i_beq(1, 0, 8));
        put(8, i_addi(27, 0, 8));
        start();
        tick(6);
        chk("br_target", dut.pc, 32'd24);
        tick(4);
        chk("br_nt_pc", dut.pc, 32'd40);
        tick(10);
        chk("br_x3", dut.Regs[3], 32'd0);
        chk("br_x4", dut.Regs[4], 32'd10);
        chk("br_x27", dut.Regs[27], 32'd8);

        // ---- stores, wrap, low-bit ignore ----
        reset = 1'b1;
        clear_imem();
        dut.DMemory[2]    = 32'd0;
        dut.DMemory[3]    = 32'd0;
        dut.DMemory[1023] = 32'd0;
        put(0, i_addi(6, 0, 42));
        put(1, i_st(3'b010, 6, 0, 8));
        put(2, i_st(3'b010, 6, 0, -4));
        put(3, i_addi(17, 0, 77));
        put(5, i_st(3'b010, 17, 0, 13));
        put(6, i_lw(16, 0, -4));
        put(7, i_add(29, 16, 16));
        start();
        tick(20);
        chk("st_d2", dut.DMemory[2], 32'd42);
        chk("st_wrap", dut.DMemory[1023], 32'd42);
        chk("st_lowbits", dut.DMemory[3], 32'd77);
        chk("st_lw_x16", dut.Regs[16], 32'd42);
        chk("st_lu_x29", dut.Regs[29], 32'd84);

        // ---- x0 and unsupported encodings ----
        reset = 1'b1;
        clear_imem();
        dut.DMemory[5] = 32'hDEAD_BEEF;
        put(0, i_addi(31, 0, 123));
        put(1, i_addi(18, 0, 7));
        put(5, i_addi(0, 0, 5));
        put(6, i_add(18, 0, 0));
        put(7, 32'hFFFF_FFFF);
        put(8, i_st(3'b000, 6, 0, 20));
        put(9, i_addi(20, 0, 55));
        start();
        tick(20);
        chk("x0_zero", dut.Regs[0], 32'd0);
        chk("x0_nofwd", dut.Regs[18], 32'd0);
        chk("bad_x31", dut.Regs[31], 32'd123);
        chk("bad_sb", dut.DMemory[5], 32'hDEAD_BEEF);
        chk("bad_next", dut.Regs[20], 32'd55);

        // ---- reset with a taken branch in EX ----
        reset = 1'b1;
        clear_imem();
        beq_w = i_beq(0, 0, 8);
        put(0, i_addi(21, 0, 33));
        put(1, i_addi(24, 0, 0));
        put(2, i_addi(25, 0, 0));
        put(5, i_addi(25, 0, 44));
        put(6, i_addi(24, 0, 99));
        put(7, beq_w);
        put(8, i_addi(22, 0, 5));
        start();
        tick(9);
        chk("mr_beq_ex", dut.idex.instr, beq_w);
        reset = 1'b1;
        tick(1);
        chk("mr_pc", dut.pc, 32'd0);
        chk("mr_x25", dut.Regs[25], 32'd0);
        chk("mr_x24", dut.Regs[24], 32'd0);
        chk("mr_x21", dut.Regs[21], 32'd33);
        chk("mr_exmem", dut.exmem.instr, NOPW);
        chk("mr_memwb", dut.memwb.instr, NOPW);
        reset = 1'b0;
        tick(1);
        chk("mr_pc_next", dut.pc, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
